filter_frame_sequencer: RTL and testbench
=========================================

// Module: filter_frame_sequencer
// PURPOSE
//  Sequences one frame of pixels through an ap_ctrl_hs pixel filter (invert/grayscale HLS cores).
//  Walks addresses over the three RGB source BRAMs and waits out the BRAM read latency.
//  Drives ap_start under handshake, captures filter results and writes them to a 24-bit result BRAM.
//  Sits between the top-level start control and the BRAM/filter datapath, replacing free-running address logic.
// PARAMETERS
//  ADDR_W   9    source/result BRAM address width
//  NUM_PIX  256  pixels per frame; legal range 1..2**ADDR_W
//  RD_LAT   1    source BRAM read latency in cycles; legal range 1..4
//  DATA_W   8    bits per colour channel
// PORTS
//  clk         in   1          clock
//  reset       in   1          synchronous, active-high reset
//  start       in   1          frame request; sampled only in IDLE
//  busy        out  1          high in every state except IDLE
//  frame_done  out  1          1-cycle pulse when the last pixel has been written
//  err         out  1          sticky protocol error flag
//  mem_en      out  1          source BRAM enable
//  mem_addr    out  ADDR_W     source BRAM address
//  ap_start    out  1          filter start
//  ap_ready    in   1          filter has accepted its inputs
//  ap_done     in   1          filter outputs are valid this cycle
//  ap_idle     in   1          filter idle (used for err check only)
//  new_r/g/b   in   DATA_W     filter outputs, one port per channel
//  out_we      out  1          result BRAM write enable
//  out_addr    out  ADDR_W     result BRAM address
//  out_data    out  3*DATA_W   captured pixel {r,g,b}
//  pix_count   out  ADDR_W+1   pixels written in the current frame
//  checksum    out  32         frame checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output is 0, state is IDLE, pixel index idx is 0, err is cleared. Reset mid-frame aborts with no further writes.
//  FSM:
//   IDLE    -> FETCH on start; pix_count cleared on this transition.
//   FETCH   mem_en=1, mem_addr=idx -> WAIT_RD.
//   WAIT_RD hold RD_LAT cycles -> KICK.
//   KICK    ap_start=1, held until ap_ready.
//           ap_ready&ap_done: capture new_* -> WRITE.
//           ap_ready only -> WAIT_DONE.
//   WAIT_DONE ap_start=0; on ap_done: capture -> WRITE.
//   WRITE   out_we=1 for exactly 1 cycle, out_addr=idx, pix_count++.
//           idx==NUM_PIX-1 -> FINISH with idx=0; else idx++ -> FETCH.
//   FINISH  frame_done=1 -> IDLE.
//  mem_addr and mem_en stay stable from FETCH until WRITE, so the BRAM output holds during the handshake.
//  Throughput: 3+RD_LAT cycles per pixel with a combinational filter. RD_LAT=1 gives 4 cycles.
//  Address wrap: idx never exceeds NUM_PIX-1; mem_addr returns to 0 after the last pixel.
//  start is ignored while busy; no queuing.
//  err is set and held until reset on either condition:
//   ap_done seen in IDLE, FETCH, WAIT_RD or WRITE;
//   ap_idle=0 at FETCH entry.
//  err does not alter sequencing.
//  out_data holds the last captured value until the next capture.
// CONFIGURATION
//  FILT_CHECKSUM_EN defined:
//   checksum = 32-bit wrapping sum of r+g+b of every written pixel.
//   Cleared on IDLE->FETCH; final value valid from the frame_done cycle until the next start.
//  Not defined: checksum tied to 0, no accumulator logic; port list unchanged.
// STRUCTURE
//  Package filt_seq_pkg holds:
//   state enum (IDLE, FETCH, WAIT_RD, KICK, WAIT_DONE, WRITE, FINISH);
//   pixel struct {r,g,b};
//   PIX_W = 3*DATA_W.
//  Sub-module filt_seq_cksum: accumulator instantiated only under FILT_CHECKSUM_EN.
//  FSM, index counter and read-latency counter stay in this module.
// TESTING
//  Test parameters: NUM_PIX=4, RD_LAT=1. Filter model is combinational: ready=done=ap_start, out = ~in.
//  Source BRAM holds r=g=b=addr.
//  1. start pulse at cycle 0 -> out_we at cycles 4,8,12,16 with out_addr 0..3 and out_data 0xFFFFFF,0xFEFEFE,0xFDFDFD,0xFCFCFC.
//     frame_done at cycle 17; pix_count=4.
//  2. Filter: ap_ready in the KICK cycle, ap_done 3 cycles later.
//     -> ap_start high for 1 cycle only; capture on the ap_done cycle; 7 cycles per pixel.
//  3. start re-pulsed at cycle 6 -> ignored; exactly one frame_done; no extra writes.
//  4. reset during the 3rd pixel -> next cycle busy=0, out_we=0, mem_addr=0.
//     A following start writes addr 0 first.
//  5. ap_done pulsed while IDLE -> err=1 and stays 1; a subsequent frame still matches test 1.
//  6. Source pixels 0x010203 x4 -> checksum=24 at frame_done with FILT_CHECKSUM_EN; 0 without.

Source files
------------

// File: rtl/filt_seq_pkg.sv
// Shared types for the filter frame sequencer: FSM state encoding and the
// packed {r,g,b} pixel carried between the filter and the result BRAM.
package filt_seq_pkg;

  localparam int DATA_W = 8;
  localparam int PIX_W  = 3 * DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    KICK,
    WAIT_DONE,
    WRITE,
    FINISH
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/filt_seq_cksum.sv
// Frame checksum accumulator: wrapping 32-bit sum of r+g+b over written pixels.
// Only instantiated when FILT_CHECKSUM_EN is defined.
module filt_seq_cksum
  import filt_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        add_i,
  input  pixel_t      pix_i,
  output logic [31:0] sum_o
);

  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      sum_q <= 32'd0;
    end else if (add_i) begin
      sum_q <= sum_q + 32'(pix_i.r) + 32'(pix_i.g) + 32'(pix_i.b);
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/filter_frame_sequencer.sv
// Walks one frame of pixels from the RGB source BRAMs through an ap_ctrl_hs
// filter into the result BRAM. Optional checksum under FILT_CHECKSUM_EN.
module filter_frame_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int NUM_PIX = 256,
  parameter int RD_LAT  = 1,
  parameter int DATA_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic                  ap_idle,
  input  logic [DATA_W-1:0]     new_r,
  input  logic [DATA_W-1:0]     new_g,
  input  logic [DATA_W-1:0]     new_b,
  output logic                  out_we,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [3*DATA_W-1:0]   out_data,
  output logic [ADDR_W:0]       pix_count,
  output logic [31:0]           checksum
);
  import filt_seq_pkg::*;

  localparam int LAT_W = 2;

  state_e                state_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  busy_q, done_q, err_q, mem_en_q, ap_start_q, we_q;
  logic [ADDR_W-1:0]     mem_addr_q, out_addr_q;
  logic [3*DATA_W-1:0]   out_data_q;
  logic [ADDR_W:0]       cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      ap_start_q <= 1'b0;
      we_q       <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      // Protocol checks only flag; they never steer the sequence.
      if (ap_done && (state_q inside {IDLE, FETCH, WAIT_RD, WRITE})) err_q <= 1'b1;
      if (state_q == FETCH && !ap_idle) err_q <= 1'b1;

      case (state_q)
        IDLE: if (start) begin
          state_q    <= FETCH;
          busy_q     <= 1'b1;
          mem_en_q   <= 1'b1;
          mem_addr_q <= idx_q;
          cnt_q      <= '0;
        end
        FETCH: begin
          state_q <= WAIT_RD;
          lat_q   <= '0;
        end
        WAIT_RD: begin
          if (lat_q == LAT_W'(RD_LAT - 1)) begin
            state_q    <= KICK;
            ap_start_q <= 1'b1;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        KICK: if (ap_ready) begin
          ap_start_q <= 1'b0;
          if (ap_done) begin
            state_q    <= WRITE;
            out_data_q <= {new_r, new_g, new_b};
            out_addr_q <= idx_q;
            we_q       <= 1'b1;
          end else begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: if (ap_done) begin
          state_q    <= WRITE;
          out_data_q <= {new_r, new_g, new_b};
          out_addr_q <= idx_q;
          we_q       <= 1'b1;
        end
        WRITE: begin
          cnt_q <= cnt_q + (ADDR_W+1)'(1);
          if (idx_q == ADDR_W'(NUM_PIX - 1)) begin
            state_q    <= FINISH;
            idx_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b1;
          end else begin
            state_q    <= FETCH;
            idx_q      <= idx_q + ADDR_W'(1);
            mem_addr_q <= idx_q + ADDR_W'(1);
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err        = err_q;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign ap_start   = ap_start_q;
  assign out_we     = we_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign pix_count  = cnt_q;

`ifdef FILT_CHECKSUM_EN
  filt_seq_cksum u_cksum (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == IDLE && start),
    .add_i (we_q),
    .pix_i (out_data_q),
    .sum_o (checksum)
  );
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed + randomized bench for filter_frame_sequencer (NUM_PIX=4, RD_LAT=1)
// against a timeline model derived from per-pixel period arithmetic.
module tb_filter_frame_sequencer;

  localparam int AW = 9, NP = 4, RL = 1, DW = 8;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, frame_done, err, mem_en, ap_start, ap_ready, ap_done, ap_idle, out_we;
  logic [AW-1:0]   mem_addr, out_addr;
  logic [DW-1:0]   new_r, new_g, new_b;
  logic [3*DW-1:0] out_data;
  logic [AW:0]     pix_count;
  logic [31:0]     checksum;

  int checks = 0, errors = 0, cyc = 0;
  logic [23:0] src [NP];
  logic [23:0] rdata = 24'd0;
  bit invert = 1'b1, force_done = 1'b0;
  int extra = 0, dcnt = 0;

  filter_frame_sequencer #(.ADDR_W(AW), .NUM_PIX(NP), .RD_LAT(RL), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .err(err), .mem_en(mem_en), .mem_addr(mem_addr), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .new_r(new_r), .new_g(new_g), .new_b(new_b), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data), .pix_count(pix_count), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source BRAM (1-cycle latency) and filter model: comb when extra==0,
  // otherwise ready with start and done `extra` cycles later.
  always @(posedge clk) if (mem_en) rdata <= src[mem_addr[1:0]];
  always @(posedge clk) begin
    if (ap_start && ap_ready && extra > 0) dcnt <= extra;
    else if (dcnt > 0) dcnt <= dcnt - 1;
  end
  assign ap_ready = ap_start;
  assign ap_done  = force_done | ((extra == 0) ? ap_start : (dcnt == 1));
  assign ap_idle  = 1'b1;
  assign {new_r, new_g, new_b} = invert ? ~rdata : rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int rep_off, input bit exp_err);
    int p, t0, off, k, ph;
    logic [31:0] sum, ce;
    logic [23:0] d;
    p = 3 + RL + extra;
    sum = 0;
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < p*NP + 3; n++) begin
      off = cyc - t0;
      start = (off == rep_off);
      k  = (off - 1) / p;
      ph = (off - 1) % p;
      if (k < NP) begin
        chk("busy", busy, 1);
        chk("mem_en", mem_en, 1);
        chk("mem_addr", mem_addr, k);
        chk("ap_start", ap_start, ph == RL + 1);
        chk("out_we", out_we, ph == p - 1);
        chk("frame_done", frame_done, 0);
        if (ph == p - 1) begin
          d = invert ? ~src[k] : src[k];
          sum += d[23:16] + d[15:8] + d[7:0];
          chk("out_addr", out_addr, k);
          chk("out_data", out_data, d);
        end
      end else begin
        chk("out_we_tail", out_we, 0);
        chk("frame_done", frame_done, off == p*NP + 1);
        chk("busy_tail", busy, off == p*NP + 1);
        if (off == p*NP + 1) begin
`ifdef FILT_CHECKSUM_EN
          ce = sum;
`else
          ce = 32'd0;
`endif
          chk("pix_count", pix_count, NP);
          chk("checksum", checksum, ce);
          chk("err", err, exp_err);
          chk("mem_addr_wrap", mem_addr, 0);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) src[i] = 24'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);        chk("rst_done", frame_done, 0);
    chk("rst_err", err, 0);          chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_ap_start", ap_start, 0);
    chk("rst_out_we", out_we, 0);    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0); chk("rst_pix_count", pix_count, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;

    // Frame with r=g=b=addr through an inverting combinational filter.
    for (int i = 0; i < NP; i++) src[i] = {3{8'(i)}};
    invert = 1'b1; extra = 0;
    run_frame(-1, 1'b0);

    // Slow filter: done 3 cycles after ready.
    extra = 3;
    run_frame(-1, 1'b0);

    // Start re-pulsed mid-frame is ignored.
    extra = 0;
    for (int i = 0; i < NP; i++) src[i] = 24'($urandom);
    run_frame(6, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NP; i++) src[i] = 24'($urandom);
      invert = 1'($urandom_range(0, 1));
      extra  = $urandom_range(0, 3);
      run_frame(-1, 1'b0);
    end

    // Reset while fetching the third pixel aborts the frame.
    extra = 0; invert = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_we", out_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_pix_count", pix_count, 0);
    run_frame(-1, 1'b0);

    // Pass-through filter, constant pixels.
    invert = 1'b0;
    for (int i = 0; i < NP; i++) src[i] = 24'h010203;
    run_frame(-1, 1'b0);

    // ap_done while idle sets sticky err; sequencing is unaffected.
    invert = 1'b1;
    for (int i = 0; i < NP; i++) src[i] = {3{8'(i)}};
    @(negedge clk); force_done = 1'b1;
    @(negedge clk); force_done = 1'b0;
    chk("err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("err_hold", err, 1);
    run_frame(-1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
